// File: rtl/lpdaq_axil_pkg.sv
// Shared definitions for the LPDAQ AXI4-Lite bridges.
//
// Contents:
//   ADDR_DATA / ADDR_STATUS / ADDR_CTRL  word indices (byte address bits [5:2])
//   resp_t                               AXI response encoding (OKAY / SLVERR)
//   decode_resp()                        response for a given word index
package lpdaq_axil_pkg;

    // Word indices: byte addresses 0x00, 0x04 and 0x08.
    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Any mapped register answers OKAY; everything else is a slave error.
    function automatic resp_t decode_resp(input logic [3:0] word_addr);
        if (word_addr == ADDR_DATA || word_addr == ADDR_STATUS || word_addr == ADDR_CTRL) begin
            return RESP_OKAY;
        end
        return RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous FIFO feeding the AXI-Stream master of the transmit bridge.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored while full)
//   pop              remove the head entry (ignored while empty)
//   flush            discard all entries; wins over a same-cycle pop
//   head_data        current head entry, 0 while empty
//   level            current occupancy, 0..DEPTH
//   full, empty      occupancy flags derived from level
module axis_tx_fifo #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Gate the head so the stream data bus reads 0 whenever nothing is valid.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axi4lite_stream_tx_if.sv
// CPU-to-stream bridge: AXI4-Lite slave whose DATA writes are queued in a small FIFO and
// replayed on an AXI-Stream master toward the DAC/config datapath.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axi_aw*           write address: awaddr[5:0], awprot, awvalid -> awready
//   s_axi_w*            write data: wdata, wstrb, wvalid -> wready
//   s_axi_b*            write response: bresp, bvalid <- bready
//   s_axi_ar*           read address: araddr[5:0], arprot, arvalid -> arready
//   s_axi_r*            read data: rdata, rresp, rvalid <- rready
//   m_axis_tdata/tvalid FIFO head / FIFO not empty; m_axis_tready accepts a beat
//   fifo_level          current FIFO occupancy
//
// Register map (byte address): 0x00 DATA, 0x04 STATUS {full, empty, level[7:0]},
// 0x08 CTRL (bit0 = flush, reads 0). Unmapped addresses return SLVERR.
module axi4lite_stream_tx_if
    import lpdaq_axil_pkg::*;
#(
    parameter int unsigned AXI_DW  = 32,
    parameter int unsigned AXIS_DW = 24,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // Write address
    input  logic [5:0]               s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    // Write data
    input  logic [AXI_DW-1:0]        s_axi_wdata,
    input  logic [AXI_DW/8-1:0]      s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    // Write response
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    // Read address
    input  logic [5:0]               s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    // Read data
    output logic [AXI_DW-1:0]        s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    // Stream master
    output logic [AXIS_DW-1:0]       m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = AXI_DW / 8;

    // Keeps every ready low during reset and for the first edge after it.
    logic                ready_en_q;

    // Write-channel holding registers
    logic                aw_held_q, aw_held_d;
    logic [3:0]          aw_word_q, aw_word_d;
    logic                w_held_q, w_held_d;
    logic [AXIS_DW-1:0]  w_data_q, w_data_d;
    logic [SW-1:0]       w_strb_q, w_strb_d;

    // Response registers
    logic                bvalid_q, bvalid_d;
    resp_t               bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    resp_t               rresp_q, rresp_d;
    logic [AXI_DW-1:0]   rdata_q, rdata_d;

    // Last word pushed, already sign-extended for DATA reads
    logic [AXI_DW-1:0]   last_q, last_d;

    logic                aw_hs, w_hs, ar_hs;
    logic                wr_is_data, wr_is_ctrl;
    logic                exec;
    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [LW-1:0]       level;
    logic [3:0]          ar_word;
    logic [AXI_DW-1:0]   data_sext;
    logic [AXI_DW-1:0]   status_word;
    logic                unused_inputs;

    assign s_axi_awready = ready_en_q & ~aw_held_q;
    assign s_axi_wready  = ready_en_q & ~w_held_q;
    assign s_axi_arready = ready_en_q & ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign fifo_level    = level;
    assign m_axis_tvalid = ~fifo_empty;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    assign ar_word    = s_axi_araddr[5:2];
    assign wr_is_data = (aw_word_q == ADDR_DATA);
    assign wr_is_ctrl = (aw_word_q == ADDR_CTRL);

    // A DATA write waits for room while AW/W stay held, so the master sees back-pressure
    // through awready/wready rather than a dropped word.
    assign exec       = aw_held_q & w_held_q & ~bvalid_q & ~(wr_is_data & fifo_full);
    assign fifo_push  = exec & wr_is_data & (|w_strb_q);
    assign fifo_flush = exec & wr_is_ctrl & w_data_q[0];
    assign fifo_pop   = m_axis_tvalid & m_axis_tready;

    assign data_sext   = {{(AXI_DW - AXIS_DW){w_data_q[AXIS_DW-1]}}, w_data_q};
    assign status_word = {{(AXI_DW - 10){1'b0}}, fifo_full, fifo_empty, 8'(level)};

    // Protection bits, byte-lane address bits and the untransmitted upper data bits are
    // intentionally ignored.
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                             s_axi_wdata[AXI_DW-1:AXIS_DW]};

    // Write path
    always_comb begin
        aw_held_d = aw_held_q;
        aw_word_d = aw_word_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        last_d    = last_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_word_d = s_axi_awaddr[5:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi_wdata[AXIS_DW-1:0];
            w_strb_d = s_axi_wstrb;
        end

        if (exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = decode_resp(aw_word_q);
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (fifo_push) begin
            last_d = data_sext;
        end
    end

    // Read path: one-cycle registered response
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = decode_resp(ar_word);
            case (ar_word)
                ADDR_DATA:   rdata_d = last_q;
                ADDR_STATUS: rdata_d = status_word;
                default:     rdata_d = '0;
            endcase
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_word_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            last_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_word_q  <= aw_word_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            last_q     <= last_d;
        end
    end

    axis_tx_fifo #(
        .DW    (AXIS_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (w_data_q),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (m_axis_tdata),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_axi4lite_stream_tx_if.sv
module tb_axi4lite_stream_tx_if;
    import lpdaq_axil_pkg::*;

    localparam int unsigned AXI_DW  = 32;
    localparam int unsigned AXIS_DW = 24;
    localparam int unsigned DEPTH   = 4;

    localparam logic [5:0] A_DATA   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_CTRL   = 6'h08;
    localparam logic [5:0] A_BAD    = 6'h3C;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          s_axi_awaddr;
    logic [2:0]          s_axi_awprot;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [AXI_DW-1:0]   s_axi_wdata;
    logic [3:0]          s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [5:0]          s_axi_araddr;
    logic [2:0]          s_axi_arprot;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [AXI_DW-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [AXIS_DW-1:0]  m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [2:0]          fifo_level;

    axi4lite_stream_tx_if #(
        .AXI_DW  (AXI_DW),
        .AXIS_DW (AXIS_DW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words still owed to the stream, and the last word pushed.
    logic [23:0] exp_q[$];
    logic [31:0] last_model = '0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // A DATA write with any strobe set queues the low 24 bits for the stream.
    function automatic void model_write(input logic [5:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        if (a[5:2] == 4'h0 && s != 4'h0) begin
            exp_q.push_back(d[23:0]);
            last_model = {{8{d[23]}}, d[23:0]};
        end
    endfunction

    // All tasks are entered and return just after a falling edge.
    task automatic send_aw(input logic [5:0] a);
        int n = 0;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_awready) timeout("aw_handshake");
        @(negedge clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_wready) timeout("w_handshake");
        @(negedge clk);
        s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_bvalid) timeout("b_response");
        resp = s_axi_bresp;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, output logic [1:0] resp);
        model_write(a, d, s);
        case (order)
            0: fork
                begin send_aw(a); end
                begin send_w(d, s); end
            join
            1: begin send_aw(a); send_w(d, s); end
            default: begin send_w(d, s); send_aw(a); end
        endcase
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_arready) timeout("ar_handshake");
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_rvalid) timeout("r_response");
        d = s_axi_rdata;
        r = s_axi_rresp;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        m_axis_tready = 1'b1;
        while ((fifo_level != 0 || m_axis_tvalid) && n < 200) begin @(negedge clk); n++; end
        check("drain_level", 32'(fifo_level), 32'd0);
    endtask

    // Stream monitor: every accepted beat must be the oldest owed word.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst && m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_beat: got 0x%0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_beat", 32'(m_axis_tdata), 32'(e));
                end
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs[13];
    logic [1:0]  resp;
    logic [31:0] rd;
    bit          rand_en;

    initial begin
        vecs[0]  = '{1'b1, A_DATA,   32'h00ABCDEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, A_DATA,   32'h0,        4'h0, 2'b00, 32'hFFABCDEF};
        vecs[2]  = '{1'b1, A_DATA,   32'h12345678, 4'h0, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, A_DATA,   32'h0,        4'h0, 2'b00, 32'hFFABCDEF};
        vecs[4]  = '{1'b1, A_DATA,   32'hFF123456, 4'h1, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, A_DATA,   32'h0,        4'h0, 2'b00, 32'h00123456};
        vecs[6]  = '{1'b0, A_STATUS, 32'h0,        4'h0, 2'b00, 32'h00000100};
        vecs[7]  = '{1'b1, A_STATUS, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, A_CTRL,   32'h0,        4'h0, 2'b00, 32'h0};
        vecs[9]  = '{1'b1, A_CTRL,   32'h00000000, 4'hF, 2'b00, 32'h0};
        vecs[10] = '{1'b1, A_BAD,    32'h00000055, 4'hF, 2'b10, 32'h0};
        vecs[11] = '{1'b0, A_BAD,    32'h0,        4'h0, 2'b10, 32'h0};
        vecs[12] = '{1'b0, 6'h0C,    32'h0,        4'h0, 2'b10, 32'h0};

        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axis_tready = 1'b0;

        // 1. Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready",  32'(s_axi_wready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_bvalid",  32'(s_axi_bvalid), 0);
        check("rst_rvalid",  32'(s_axi_rvalid), 0);
        check("rst_bresp_rresp", 32'({s_axi_bresp, s_axi_rresp}), 0);
        check("rst_rdata",   s_axi_rdata, 0);
        check("rst_tvalid",  32'(m_axis_tvalid), 0);
        check("rst_tdata",   32'(m_axis_tdata), 0);
        check("rst_level",   32'(fifo_level), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // 2. AW before W, bvalid and a single stream beat
        m_axis_tready = 1'b1;
        model_write(A_DATA, 32'h00ABCDEF, 4'hF);
        send_aw(A_DATA);
        send_w(32'h00ABCDEF, 4'hF);
        check("t2_bvalid_before_exec", 32'(s_axi_bvalid), 0);
        @(negedge clk);
        check("t2_bvalid", 32'(s_axi_bvalid), 1);
        check("t2_tvalid", 32'(m_axis_tvalid), 1);
        check("t2_tdata",  32'(m_axis_tdata), 32'h00ABCDEF);
        wait_b(resp);
        check("t2_bresp",  32'(resp), 0);
        check("t2_tvalid_pulse_end", 32'(m_axis_tvalid), 0);

        // Table of single transactions with a free-running sink
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        wait_drain();

        // 3. Fill with the sink stalled; the fifth write must be held back
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_write(A_DATA, 32'h00C00000 + 32'(i), 4'hF, i % 3, resp);
            check("t3_bresp", 32'(resp), 0);
        end
        check("t3_level_full", 32'(fifo_level), 4);
        model_write(A_DATA, 32'h00C00004, 4'hF);
        send_aw(A_DATA);
        send_w(32'h00C00004, 4'hF);
        repeat (5) @(negedge clk);
        check("t3_stall_bvalid",  32'(s_axi_bvalid), 0);
        check("t3_stall_awready", 32'(s_axi_awready), 0);
        check("t3_stall_wready",  32'(s_axi_wready), 0);
        axi_read(A_STATUS, rd, resp);
        check("t3_status", rd, 32'h204);
        m_axis_tready = 1'b1;
        wait_b(resp);
        check("t3_fifth_bresp", 32'(resp), 0);
        wait_drain();

        // 4. Flush with two words pending while the sink toggles
        m_axis_tready = 1'b0;
        axi_write(A_DATA, 32'h00000011, 4'hF, 0, resp);
        axi_write(A_DATA, 32'h00000022, 4'hF, 1, resp);
        check("t4_level_before", 32'(fifo_level), 2);
        mon_en = 1'b0;
        fork
            begin axi_write(A_CTRL, 32'h1, 4'hF, 0, resp); end
            begin
                repeat (6) begin @(negedge clk); m_axis_tready = ~m_axis_tready; end
                m_axis_tready = 1'b0;
            end
        join
        check("t4_ctrl_bresp", 32'(resp), 0);
        check("t4_level_after", 32'(fifo_level), 0);
        check("t4_tvalid_after", 32'(m_axis_tvalid), 0);
        exp_q.delete();
        mon_en = 1'b1;
        axi_read(A_STATUS, rd, resp);
        check("t4_status", rd, 32'h100);

        // 5. Unmapped write leaves the FIFO alone
        axi_write(A_DATA, 32'h00000777, 4'hF, 2, resp);
        axi_write(A_BAD, 32'h00000888, 4'hF, 0, resp);
        check("t5_bad_bresp", 32'(resp), 32'(2'b10));
        check("t5_level", 32'(fifo_level), 1);
        axi_read(A_BAD, rd, resp);
        check("t5_bad_rresp", 32'(resp), 32'(2'b10));
        check("t5_bad_rdata", rd, 0);
        wait_drain();

        // 6. Asynchronous reset with AW held and a word pending
        m_axis_tready = 1'b0;
        axi_write(A_DATA, 32'h00F00F00, 4'hF, 0, resp);
        send_aw(A_DATA);
        check("t6_aw_held", 32'(s_axi_awready), 0);
        check("t6_tvalid_pre", 32'(m_axis_tvalid), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("t6_rst_level", 32'(fifo_level), 0);
        check("t6_rst_bvalid", 32'(s_axi_bvalid), 0);
        check("t6_rst_awready", 32'(s_axi_awready), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        axi_write(A_DATA, 32'h00123ABC, 4'hF, 1, resp);
        check("t6_post_bresp", 32'(resp), 0);
        wait_drain();
        axi_read(A_DATA, rd, resp);
        check("t6_post_rdata", rd, 32'h00123ABC);

        // Randomised traffic against the model, with a random sink
        rand_en = 1'b1;
        fork
            begin
                while (rand_en) begin
                    @(negedge clk);
                    m_axis_tready = ($urandom % 2) == 1;
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    int          k;
                    logic [31:0] d;
                    logic [3:0]  s;
                    logic [5:0]  a;
                    k = $urandom_range(0, 5);
                    d = $urandom;
                    s = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom);
                    case (k)
                        0, 1: begin
                            axi_write({4'h0, 2'($urandom)}, d, s, $urandom_range(0, 2), resp);
                            check("rnd_data_bresp", 32'(resp), 0);
                        end
                        2: begin
                            axi_read(A_DATA, rd, resp);
                            check("rnd_data_rdata", rd, last_model);
                        end
                        3: begin
                            axi_read(A_STATUS, rd, resp);
                            check("rnd_status_rresp", 32'(resp), 0);
                            check("rnd_status_flags", {rd[31:10], rd[9], rd[8]},
                                  {22'h0, rd[7:0] == 8'd4, rd[7:0] == 8'd0});
                        end
                        4: begin
                            a = {4'($urandom_range(3, 15)), 2'($urandom)};
                            axi_write(a, d, s, $urandom_range(0, 2), resp);
                            check("rnd_bad_bresp", 32'(resp), 32'(2'b10));
                        end
                        default: begin
                            axi_write(A_CTRL, d & 32'hFFFF_FFFE, 4'hF, $urandom_range(0, 2),
                                      resp);
                            check("rnd_ctrl_bresp", 32'(resp), 0);
                            axi_read(A_CTRL, rd, resp);
                            check("rnd_ctrl_rdata", rd, 0);
                        end
                    endcase
                end
                rand_en = 1'b0;
            end
        join
        wait_drain();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
